// File: rtl/wb_write_port.sv
// Register-file write-port arbiter: pipeline writes win, MDU results bypass or wait in a 2-entry buffer.
// Output is registered (1 cycle); mdu_ready drops while the buffer is full, and the MDU holds its result until it rises.
module wb_write_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_regwrite,
    input  logic        wb_memtoreg,
    input  logic [31:0] wb_alu_result,
    input  logic [31:0] wb_mem_data,
    input  logic [4:0]  wb_dest,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dest,
    input  logic [31:0] mdu_result,
    output logic        mdu_ready,
    input  logic [4:0]  query_rs,
    input  logic [4:0]  query_rt,
    output logic        pending_hit,
    output logic [4:0]  writeregister,
    output logic [31:0] data,
    output logic        regWrite
);

    logic [1:0]  vld_q, vld_d;
    logic [4:0]  dest_q [2];
    logic [31:0] res_q  [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;

    logic pipe_req, full, empty, mdu_live, pop, bypass, push;

    assign pipe_req  = wb_valid && wb_regwrite && (wb_dest != 5'd0);
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign mdu_ready = !full;
    // Transfers to r0 complete the handshake but are dropped here.
    assign mdu_live  = mdu_valid && mdu_ready && (mdu_dest != 5'd0);
    assign pop       = !pipe_req && !empty;
    assign bypass    = !pipe_req && empty && mdu_live;
    assign push      = mdu_live && !bypass;

    always_comb begin
        vld_d   = vld_q;
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        wreg_d  = wreg_q;
        data_d  = data_q;
        we_d    = 1'b0;

        // The younger pipeline write makes any buffered value for the same register stale.
        for (int i = 0; i < 2; i++) begin
            if (pipe_req && dest_q[i] == wb_dest) begin
                vld_d[i] = 1'b0;
            end
        end
        if (pop) begin
            vld_d[head_q] = 1'b0;
        end
        if (push) begin
            vld_d[tail_q] = !(pipe_req && mdu_dest == wb_dest);
        end

        if (pipe_req) begin
            wreg_d = wb_dest;
            data_d = wb_memtoreg ? wb_mem_data : wb_alu_result;
            we_d   = 1'b1;
        end else if (pop) begin
            if (vld_q[head_q]) begin
                wreg_d = dest_q[head_q];
                data_d = res_q[head_q];
                we_d   = 1'b1;
            end
        end else if (bypass) begin
            wreg_d = mdu_dest;
            data_d = mdu_result;
            we_d   = 1'b1;
        end
    end

    always_comb begin
        pending_hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (vld_q[i] && (((query_rs != 5'd0) && (dest_q[i] == query_rs)) ||
                             ((query_rt != 5'd0) && (dest_q[i] == query_rt)))) begin
                pending_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= 2'b00;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            wreg_q  <= 5'd0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wreg_q  <= wreg_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail_q] <= mdu_dest;
            res_q[tail_q]  <= mdu_result;
        end
    end

    assign writeregister = wreg_q;
    assign data          = data_q;
    assign regWrite      = we_q;

endmodule

// File: tb/tb_wb_write_port.sv
// Scenario bench for wb_write_port: expected writes are queued at stimulus time and checked as they appear.
module tb_wb_write_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_regwrite, wb_memtoreg;
    logic [31:0] wb_alu_result, wb_mem_data;
    logic [4:0]  wb_dest;
    logic        mdu_valid;
    logic [4:0]  mdu_dest;
    logic [31:0] mdu_result;
    logic        mdu_ready;
    logic [4:0]  query_rs, query_rt;
    logic        pending_hit;
    logic [4:0]  writeregister;
    logic [31:0] data;
    logic        regWrite;

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [36:0] exp_q [$];

    wb_write_port dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_dest(wb_dest),
        .mdu_valid(mdu_valid), .mdu_dest(mdu_dest), .mdu_result(mdu_result),
        .mdu_ready(mdu_ready), .query_rs(query_rs), .query_rt(query_rt),
        .pending_hit(pending_hit), .writeregister(writeregister), .data(data),
        .regWrite(regWrite)
    );

    always #5 clk = ~clk;

    task automatic set_pipe(input logic v, input logic mtr, input logic [4:0] d,
                            input logic [31:0] alu, input logic [31:0] mem);
        wb_valid = v; wb_regwrite = v; wb_memtoreg = mtr;
        wb_dest = d; wb_alu_result = alu; wb_mem_data = mem;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] d, input logic [31:0] r);
        mdu_valid = v; mdu_dest = d; mdu_result = r;
    endtask

    task automatic set_idle();
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0);
    endtask

    task automatic exp_push(input logic [4:0] d, input logic [31:0] v);
        exp_q.push_back({d, v});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            set_idle();
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        set_idle();
        query_rs = 5'd0; query_rt = 5'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({writeregister, data, regWrite, mdu_ready, pending_hit} !== {5'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: wr=%0d data=%h we=%b rdy=%b hit=%b, required 0 0 0 1 0",
                     writeregister, data, regWrite, mdu_ready, pending_hit);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_alu_load();
        @(negedge clk);
        set_pipe(1'b1, 1'b0, 5'd8, 32'h0000_1234, 32'hFFFF_0000);
        exp_push(5'd8, 32'h0000_1234);
        @(negedge clk);
        set_pipe(1'b1, 1'b1, 5'd7, 32'h1111_1111, 32'hDEAD_BEEF);
        exp_push(5'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        #1;
        checks++;
        if (regWrite !== 1'b0) begin
            errors++;
            $display("FAIL alu_drop: regWrite=%b, required 0", regWrite);
        end
        wait_drain();
    endtask

    task automatic test_zero();
        @(negedge clk);
        set_pipe(1'b1, 1'b0, 5'd0, 32'hAAAA_AAAA, 32'd0);
        @(negedge clk);
        set_idle();
        set_mdu(1'b1, 5'd0, 32'hBBBB_BBBB);
        #1;
        checks++;
        if ({regWrite, mdu_ready} !== 2'b01) begin
            errors++;
            $display("FAIL zero_pipe: we=%b rdy=%b, required 0 1", regWrite, mdu_ready);
        end
        @(negedge clk);
        set_idle();
        @(negedge clk);
        #1;
        checks++;
        if ({regWrite, mdu_ready} !== 2'b01) begin
            errors++;
            $display("FAIL zero_mdu: we=%b rdy=%b, required 0 1", regWrite, mdu_ready);
        end
        wait_drain();
    endtask

    task automatic test_collision();
        @(negedge clk);
        query_rs = 5'd9;
        set_pipe(1'b1, 1'b0, 5'd8, 32'h0000_0088, 32'd0);
        set_mdu(1'b1, 5'd9, 32'h0000_CAFE);
        exp_push(5'd8, 32'h0000_0088);
        exp_push(5'd9, 32'h0000_CAFE);
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (pending_hit !== 1'b1) begin
            errors++;
            $display("FAIL coll_hit: pending_hit=%b, required 1", pending_hit);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pending_hit !== 1'b0) begin
            errors++;
            $display("FAIL coll_clear: pending_hit=%b, required 0", pending_hit);
        end
        query_rs = 5'd0;
        wait_drain();
    endtask

    task automatic test_full();
        logic [4:0]  m_dest [3];
        logic [31:0] m_res  [3];
        logic [4:0]  rdy_exp;
        int          idx;
        m_dest[0] = 5'd3; m_dest[1] = 5'd4; m_dest[2] = 5'd5;
        m_res[0] = 32'h33; m_res[1] = 32'h44; m_res[2] = 32'h55;
        rdy_exp = 5'b10011;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) begin
                set_pipe(1'b1, 1'b0, 5'(20 + i), 32'h2000 + i, 32'd0);
                exp_push(5'(20 + i), 32'h2000 + i);
            end else begin
                set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
            end
            if (i == 3) begin
                for (int k = 0; k < 3; k++) exp_push(m_dest[k], m_res[k]);
            end
            if (idx < 3) set_mdu(1'b1, m_dest[idx], m_res[idx]);
            else         set_mdu(1'b0, 5'd0, 32'd0);
            #1;
            checks++;
            if (mdu_ready !== rdy_exp[i]) begin
                errors++;
                $display("FAIL full_ready[%0d]: mdu_ready=%b, required %b", i, mdu_ready, rdy_exp[i]);
            end
            if (mdu_valid && mdu_ready) idx++;
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL full_accepts: %0d transfers, required 3", idx);
        end
        wait_drain();
    endtask

    task automatic test_squash();
        @(negedge clk);
        query_rs = 5'd10;
        set_pipe(1'b1, 1'b0, 5'd1, 32'h11, 32'd0);
        set_mdu(1'b1, 5'd10, 32'h1);
        exp_push(5'd1, 32'h11);
        @(negedge clk);
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 1'b0, 5'd10, 32'h2, 32'd0);
        exp_push(5'd10, 32'h2);
        #1;
        checks++;
        if (pending_hit !== 1'b1) begin
            errors++;
            $display("FAIL squash_pre: pending_hit=%b, required 1", pending_hit);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (pending_hit !== 1'b0) begin
            errors++;
            $display("FAIL squash_hit: pending_hit=%b, required 0", pending_hit);
        end
        @(negedge clk);
        #1;
        checks++;
        if (regWrite !== 1'b0) begin
            errors++;
            $display("FAIL squash_pop: regWrite=%b, required 0", regWrite);
        end
        query_rs = 5'd0;
        wait_drain();
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_pipe(1'b1, 1'b0, 5'(16 + 2 * k), 32'h100 + k, 32'd0);
            set_mdu(1'b1, 5'(24 + 2 * k), 32'hA00 + k);
            exp_push(5'(16 + 2 * k), 32'h100 + k);
            @(negedge clk);
            set_pipe(1'b1, 1'b1, 5'(17 + 2 * k), 32'd0, 32'h200 + k);
            set_mdu(1'b1, 5'(25 + 2 * k), 32'hB00 + k);
            exp_push(5'(17 + 2 * k), 32'h200 + k);
            @(negedge clk);
            set_idle();
            exp_push(5'(24 + 2 * k), 32'hA00 + k);
            exp_push(5'(25 + 2 * k), 32'hB00 + k);
            #1;
            checks++;
            if (mdu_ready !== 1'b0) begin
                errors++;
                $display("FAIL wrap_full[%0d]: mdu_ready=%b, required 0", k, mdu_ready);
            end
            @(negedge clk);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_mdu(1'b1, 5'(1 + i), 32'hC0DE_0000 + i);
            exp_push(5'(1 + i), 32'hC0DE_0000 + i);
            #1;
            checks++;
            if (mdu_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: mdu_ready=%b, required 1", i, mdu_ready);
            end
        end
        wait_drain();
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        query_rs = 5'd12; query_rt = 5'd14;
        set_pipe(1'b1, 1'b0, 5'd11, 32'hB, 32'd0);
        set_mdu(1'b1, 5'd12, 32'hC);
        exp_push(5'd11, 32'hB);
        @(negedge clk);
        set_pipe(1'b1, 1'b0, 5'd13, 32'hD, 32'd0);
        set_mdu(1'b1, 5'd14, 32'hE);
        exp_push(5'd13, 32'hD);
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        #1;
        checks++;
        if ({pending_hit, mdu_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midop_pre: hit=%b rdy=%b, required 1 0", pending_hit, mdu_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({regWrite, mdu_ready, pending_hit, writeregister} !== {1'b0, 1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL midop_post: we=%b rdy=%b hit=%b wr=%0d, required 0 1 0 0",
                     regWrite, mdu_ready, pending_hit, writeregister);
        end
        query_rs = 5'd0; query_rt = 5'd0;
        repeat (4) @(negedge clk);
        wait_drain();
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                #1;
                if (mon_en && regWrite === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_order: unexpected write r%0d=%h, required none", writeregister, data);
                    end else begin
                        logic [36:0] e;
                        e = exp_q.pop_front();
                        if ({writeregister, data} !== e) begin
                            errors++;
                            $display("FAIL write_order: got r%0d=%h, required r%0d=%h",
                                     writeregister, data, e[36:32], e[31:0]);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_alu_load();
        test_zero();
        test_collision();
        test_full();
        test_squash();
        test_wrap();
        test_back_to_back();
        test_reset_midop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_port.md
# wb_write_port

Writeback-stage write-port controller that owns the single write port of the register file. It merges two result sources into one registered write per cycle: the in-order MEM/WB pipeline path (ALU result or load data) and the out-of-order multicycle multiply/divide unit (MDU). MDU results that collide with pipeline writes are held in a 2-entry buffer. The block also exposes pending-write lookups so the hazard unit can stall readers of buffered destinations.

## Interface
- No parameters. Data width is fixed at 32 bits; register index width is fixed at 5 bits.
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- wb_valid  in  1  pipeline result present this cycle
- wb_regwrite  in  1  pipeline instruction writes a register
- wb_memtoreg  in  1  1 selects wb_mem_data, 0 selects wb_alu_result
- wb_alu_result  in  32  ALU result
- wb_mem_data  in  32  load data
- wb_dest  in  5  pipeline destination register
- mdu_valid  in  1  MDU result offered
- mdu_dest  in  5  MDU destination register
- mdu_result  in  32  MDU result
- mdu_ready  out  1  buffer can accept; a transfer occurs when mdu_valid && mdu_ready
- query_rs, query_rt  in  5  decode-stage source registers
- pending_hit  out  1  combinational; a buffered entry targets a nonzero query_rs or query_rt
- writeregister  out  5  register file write index (registered)
- data  out  32  register file write data (registered)
- regWrite  out  1  register file write enable (registered)

## Operation
- Pipeline write request: wb_valid && wb_regwrite && wb_dest != 0.
- An MDU transfer with mdu_dest == 0 is accepted and discarded; it never enters the buffer.
- Output selection each posedge, in priority order:
  - Pipeline request: output its dest and muxed data, and regWrite=1.
  - Otherwise, buffer non-empty: pop the head entry to the output, and regWrite=1.
  - Otherwise, an MDU transfer with nonzero dest: bypass directly to the output, and regWrite=1.
  - Otherwise: regWrite=0; writeregister and data hold their previous values.
- An MDU transfer is pushed to the buffer only when it is not bypassed (a pipeline request is present, or the buffer is non-empty).
- Buffer: 2-entry FIFO with valid bits and wrapping 1-bit head/tail pointers. Push and pop in the same cycle are both performed.
- mdu_ready = !full. It is computed from the current count and ignores a same-cycle pop.
- Squash rule: when a pipeline request writes register X, every buffered entry with dest X is invalidated in the same cycle (the younger pipeline write wins).
  - Invalid entries are skipped and freed at pop.
  - A pop of an invalid head produces regWrite=0 for that cycle.
- pending_hit considers valid buffered entries only; it does not consider the entry being pushed this cycle.

## Timing
- Reset: writeregister=0, data=0, regWrite=0. Buffer is empty with all valid bits 0, and mdu_ready=1.
- Reset mid-operation drops all buffered entries with no write issued. Reset takes priority over every other input in that cycle.
- Pipeline latency: 1 cycle from input sample to regWrite high. Outputs stay stable through the following negedge, when the register file commits.
- MDU latency: 1 cycle when bypassed. When buffered, the entry leaves on the first later cycle with no pipeline request and no older entry ahead of it.
- Full (2 entries) with mdu_valid high: no transfer, mdu_ready=0. The MDU must hold its result until mdu_ready is 1.
- Wrap-around: pointers wrap from 1 to 0 with no bubble.
- pending_hit is purely combinational from buffer state and the query inputs. Its path must not depend on current-cycle pipeline inputs.

## Test plan
- ALU write: after reset, present wb_valid=1, wb_regwrite=1, wb_memtoreg=0, wb_dest=8, alu=0x0000_1234 → next cycle writeregister=8, data=0x1234, regWrite=1. Then drop wb_valid → regWrite=0.
- Register zero: wb_dest=0, then separately mdu_dest=0 → regWrite stays 0 and the buffer count stays 0.
- Collision: pipeline write to r8 and MDU write to r9 (0xCAFE) in the same cycle → cycle+1 writes r8. Meanwhile query_rs=9 gives pending_hit=1. With the pipeline idle, cycle+2 writes r9=0xCAFE and pending_hit returns to 0.
- Full: hold three consecutive pipeline writes while the MDU offers r3, r4, r5 → r3 and r4 are accepted and mdu_ready=0 until the first pop. Drain order is r3, r4, then r5 once accepted.
- Squash: buffer an MDU entry r10=0x1, then issue a pipeline write r10=0x2 → r10=0x2 is written, the buffered entry is never written, and pending_hit for r10 is 0 afterwards.
- Reset mid-op: with 2 entries buffered, assert reset for 1 cycle → regWrite=0, mdu_ready=1, pending_hit=0, and no buffered write ever appears.
